johnson_decoder: RTL

- Receive end of the Johnson-counter interface: samples an N-bit Johnson codeword each valid cycle, checks it is legal, and decodes it to a binary step index 0..2N-1.
- Tracks sequence continuity, so each legal step must be the successor of the previous one.
- Declares lock / loss-of-lock through a small FSM.
- Sits downstream of any Johnson counter or Johnson-coded bus, for example a ring phase monitor or a self-checking counter bench.

---
 rtl/johnson_pkg.sv | 29 ++
 rtl/johnson_dec_comb.sv | 40 ++++
 rtl/johnson_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared definitions for the Johnson-code receive path.
//   - FSM state encoding used by johnson_decoder.
//   - johnson_next(): successor codeword from the sequence rule.
//     The counter and benches use the same function, so every block
//     agrees on one sequence definition.
package johnson_pkg;

  typedef logic [1:0] jst_t;

  localparam jst_t ST_UNLOCKED = 2'd0;
  localparam jst_t ST_LOCKING  = 2'd1;
  localparam jst_t ST_LOCKED   = 2'd2;

  // Widest codeword the helper function handles.
  localparam int JMAX = 64;

  // Successor of an n-bit Johnson codeword: shift left, feed back ~MSB.
  // Only the low n bits of the argument and of the result are meaningful.
  function automatic logic [JMAX-1:0] johnson_next(input logic [JMAX-1:0] code,
                                                   input int n);
    logic [JMAX-1:0] r;
    r = '0;
    for (int i = 1; i < JMAX; i++)
      if (i < n) r[i] = code[i-1];
    r[0] = ~code[n-1];
    return r;
  endfunction

endpackage

// File: rtl/johnson_dec_comb.sv
// johnson_dec_comb: purely combinational Johnson codeword checker/decoder.
//   code  [N-1:0]  in   codeword under test
//   legal          out  1 when code is one of the 2N sequence states
//   idx   [IW-1:0] out  step index 0..2N-1 (meaningful only when legal)
// MSB=0 words must be a run of ones from the LSB (idx = popcount);
// MSB=1 words must be a run of ones from the MSB (idx = 2N - popcount).
module johnson_dec_comb #(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] idx
);

  localparam int PW = $clog2(N+1);

  logic [PW-1:0] pc;
  logic [N-1:0]  lo_run;   // pc ones packed at the LSB end
  logic [N-1:0]  hi_run;   // pc ones packed at the MSB end

  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + PW'(code[i]);
    lo_run = '0;
    hi_run = '0;
    for (int i = 0; i < N; i++) begin
      lo_run[i] = (i < int'(pc));
      hi_run[i] = (i >= N - int'(pc));
    end
    if (!code[N-1]) begin
      legal = (code == lo_run);
      idx   = IW'(pc);
    end else begin
      legal = (code == hi_run);
      idx   = IW'(2*N - int'(pc));
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: receive end of a Johnson-counter interface.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   code[N-1:0] in  codeword, sampled when code_vld=1
//   code_vld   in   sample enable
//   idx[IW-1:0] out registered step index of the last legal codeword
//   idx_vld    out  1-cycle pulse, idx updated
//   code_err   out  1-cycle pulse, sampled codeword illegal
//   seq_err    out  1-cycle pulse, legal but out of sequence while LOCKED
//   locked     out  FSM is in LOCKED
//   err_cnt[7:0] out (only with JOHNSON_DECODER_ERRCNT_EN) saturating
//                count of code_err + seq_err events
// Lock requires LOCK_LEN consecutive in-sequence legal codewords.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_LEN = 3,
  localparam int IW       = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code,
  input  logic          code_vld,
  output logic [IW-1:0] idx,
  output logic          idx_vld,
  output logic          code_err,
  output logic          seq_err,
  output logic          locked
`ifdef JOHNSON_DECODER_ERRCNT_EN
  ,output logic [7:0]   err_cnt
`endif
);

  logic          legal;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] exp_idx;
  logic          in_seq;
  jst_t          st, st_nxt;
  logic [3:0]    run, run_nxt;
  logic          cerr_nxt, serr_nxt;

  johnson_dec_comb #(.N(N), .IW(IW)) u_dec (
    .code  (code),
    .legal (legal),
    .idx   (dec_idx)
  );

  // idx only ever changes on a legal codeword, so it doubles as the
  // previous-index register used for the continuity check.
  assign exp_idx = (idx == IW'(2*N-1)) ? '0 : idx + 1'b1;
  assign in_seq  = (dec_idx == exp_idx);

  always_comb begin
    st_nxt   = st;
    run_nxt  = run;
    cerr_nxt = 1'b0;
    serr_nxt = 1'b0;
    if (code_vld) begin
      if (!legal) begin
        cerr_nxt = 1'b1;
        st_nxt   = ST_UNLOCKED;
        run_nxt  = '0;
      end else begin
        case (st)
          ST_UNLOCKED: begin
            run_nxt = 4'd1;
            st_nxt  = (LOCK_LEN == 1) ? ST_LOCKED : ST_LOCKING;
          end
          ST_LOCKING: begin
            if (in_seq) begin
              // run never needs to exceed LOCK_LEN
              if (run + 4'd1 >= 4'(LOCK_LEN)) begin
                run_nxt = 4'(LOCK_LEN);
                st_nxt  = ST_LOCKED;
              end else begin
                run_nxt = run + 4'd1;
              end
            end else begin
              // restart silently; a fresh run of one already satisfies LOCK_LEN=1
              run_nxt = 4'd1;
              st_nxt  = (LOCK_LEN == 1) ? ST_LOCKED : ST_LOCKING;
            end
          end
          ST_LOCKED: begin
            if (!in_seq) begin
              serr_nxt = 1'b1;
              run_nxt  = 4'd1;
              st_nxt   = (LOCK_LEN == 1) ? ST_LOCKED : ST_LOCKING;
            end
          end
          default: begin
            st_nxt  = ST_UNLOCKED;
            run_nxt = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      idx_vld  <= 1'b0;
      code_err <= 1'b0;
      seq_err  <= 1'b0;
      locked   <= 1'b0;
      st       <= ST_UNLOCKED;
      run      <= '0;
    end else begin
      idx_vld  <= code_vld & legal;
      code_err <= cerr_nxt;
      seq_err  <= serr_nxt;
      if (code_vld && legal) idx <= dec_idx;
      st       <= st_nxt;
      run      <= run_nxt;
      locked   <= (st_nxt == ST_LOCKED);
    end
  end

`ifdef JOHNSON_DECODER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if ((cerr_nxt || serr_nxt) && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
